ro_meas_sequencer: RTL and testbench



---
 rtl/ro_meas_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_ro_meas_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_meas_sequencer.sv
// Ring-oscillator measurement sequencer: UART command -> settle -> 2^LOG2_AVG gated counts -> 24-bit sum sent LSB-first.
// Latency: result_valid 1+SETTLE_CYC+2^LOG2_AVG*(WIN_CYC+4) cycles after a single-run 'S' (zero UART time).
// Backpressure: each byte waits for tx_busy low; optional watchdog (ROTEMP_TXWDOG_EN) aborts a stuck transmitter.
//
// Ports:
//   clk1, rst_n              clock, synchronous active-low reset
//   cmd_valid, cmd_data      command strobe/byte: 'S' single, 'C' continuous, 'X' stop
//   count_in                 synchronized event-counter value
//   tx_busy                  UART transmitter busy
//   osc_en, cnt_clr, cnt_en  oscillator enable, counter clear pulse, counter gate
//   tx_start, tx_data        one-cycle byte send strobe and byte
//   result, result_valid     last completed sum and its update strobe
//   busy, err                not idle; sticky transmit watchdog error
//
// Optional feature macro: ROTEMP_TXWDOG_EN enables the tx_busy watchdog (limit TX_TMO);
// without it err is tied 0 and the controller waits on the UART indefinitely.
module ro_meas_sequencer #(
    parameter int CNT_W      = 16,
    parameter int ACC_W      = 24,
    parameter int SETTLE_CYC = 16,
    parameter int WIN_CYC    = 1000,
    parameter int LOG2_AVG   = 4,
    parameter int TX_TMO     = 65535
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [7:0]       cmd_data,
    input  logic [CNT_W-1:0] count_in,
    input  logic             tx_busy,
    output logic             osc_en,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic [ACC_W-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             err
);

    typedef enum logic [3:0] {
        S_IDLE, S_SETTLE, S_CLEAR, S_GATE, S_HOLD,
        S_CAPTURE, S_DONE, S_TX_ISSUE, S_TX_WAIT
    } state_t;

    localparam int TMR_MAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int IDX_W   = (LOG2_AVG > 0) ? LOG2_AVG : 1;

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'((1 << LOG2_AVG) - 1);

    // The sum must not overflow, the three result bytes must exist, and the
    // watchdog limit must be reachable.
    generate
        if ((LOG2_AVG > ACC_W - CNT_W) || (ACC_W < 24) || (TX_TMO < 1)) begin : g_bad_params
            $error("ro_meas_sequencer: illegal parameter combination");
        end
    endgenerate

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [IDX_W-1:0] idx;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [1:0]       ptr;
    logic             cont;
    logic             tx_first;
    logic             restart;
    logic             acc_clr;
    logic             wd_trip;
    logic [7:0]       tx_byte;

    logic cmd_s, cmd_c, cmd_x, abort;

    assign cmd_s = cmd_valid && (cmd_data == 8'h53);
    assign cmd_c = cmd_valid && (cmd_data == 8'h43);
    assign cmd_x = cmd_valid && (cmd_data == 8'h58);
    assign abort = cmd_x && (state != S_IDLE);

    assign acc_sum = acc + ACC_W'(count_in);

    always_comb begin
        case (ptr)
            2'd0:    tx_byte = result[7:0];
            2'd1:    tx_byte = result[15:8];
            default: tx_byte = result[23:16];
        endcase
    end

    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        restart   = 1'b0;
        case (state)
            S_IDLE:     if (cmd_s || cmd_c) state_nxt = S_SETTLE;
            S_SETTLE:   if (tmr == SETTLE_LAST) state_nxt = S_CLEAR;
            S_CLEAR:    state_nxt = S_GATE;
            S_GATE:     if (tmr == WIN_LAST) state_nxt = S_HOLD;
            S_HOLD:     if (tmr == HOLD_LAST) state_nxt = S_CAPTURE;
            S_CAPTURE:  state_nxt = (idx == IDX_LAST) ? S_DONE : S_CLEAR;
            S_DONE:     state_nxt = S_TX_ISSUE;
            S_TX_ISSUE: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                // The UART may not have raised tx_busy yet on the first cycle.
                if (!tx_first && !tx_busy) begin
                    if (ptr != 2'd2) begin
                        state_nxt = S_TX_ISSUE;
                    end else if (cont || cmd_c) begin
                        state_nxt = S_CLEAR;
                        restart   = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default:    state_nxt = S_IDLE;
        endcase
        // Stop and watchdog override everything, including a pending byte.
        if (abort || wd_trip) begin
            state_nxt = S_IDLE;
            tx_start  = 1'b0;
            restart   = 1'b0;
        end
    end

    // Accumulation restarts from zero whenever we go idle or loop for the next result.
    assign acc_clr = (state_nxt == S_IDLE) || restart;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tmr      <= '0;
            idx      <= '0;
            acc      <= '0;
            ptr      <= 2'd0;
            cont     <= 1'b0;
            tx_first <= 1'b0;
            result   <= '0;
        end else begin
            state    <= state_nxt;
            tmr      <= (state_nxt != state) ? '0 : tmr + 1'b1;
            tx_first <= tx_start;

            if (acc_clr) begin
                acc <= '0;
                idx <= '0;
            end else if (state == S_CAPTURE) begin
                acc <= acc_sum;
                idx <= idx + 1'b1;
            end

            if ((state == S_CAPTURE) && (idx == IDX_LAST) && !abort)
                result <= acc_sum;

            if (state == S_DONE)
                ptr <= 2'd0;
            else if ((state == S_TX_WAIT) && (state_nxt == S_TX_ISSUE))
                ptr <= ptr + 1'b1;

            if (cmd_x)
                cont <= 1'b0;
            else if (cmd_c)
                cont <= 1'b1;
            else if (cmd_s && (state == S_IDLE))
                cont <= 1'b0;
            else if (wd_trip)
                cont <= 1'b0;
        end
    end

`ifdef ROTEMP_TXWDOG_EN
    localparam int WD_W = $clog2(TX_TMO + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            in_tx;

    assign in_tx   = (state == S_TX_ISSUE) || (state == S_TX_WAIT);
    // Counts busy cycles while we own the UART; a stop command takes priority.
    assign wd_trip = in_tx && tx_busy && (wd_cnt == WD_W'(TX_TMO - 1)) && !cmd_x;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (in_tx && tx_busy && !wd_trip)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
            if (wd_trip)
                err <= 1'b1;
            else if (cmd_s || cmd_c)
                err <= 1'b0;
        end
    end
`else
    assign wd_trip = 1'b0;
    assign err     = 1'b0;
`endif

    assign osc_en       = (state != S_IDLE);
    assign busy         = (state != S_IDLE);
    assign cnt_clr      = (state == S_CLEAR);
    assign cnt_en       = (state == S_GATE);
    assign result_valid = (state == S_DONE);
    assign tx_data      = tx_start ? tx_byte : 8'h00;

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// Bench for ro_meas_sequencer: directed commands, a UART busy emulator and a
// timing model derived from the per-phase cycle counts, checked every cycle.
module tb_ro_meas_sequencer;

    localparam int S   = 4;
    localparam int W   = 10;
    localparam int L   = 2;
    localparam int N   = 4;
    localparam int TMO = 8;
    localparam int P_IDLE = 0, P_MEAS = 1, P_TXI = 2, P_TXW = 3;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_data = 8'h00;
    logic [15:0] count_in = 16'h0000;
    logic        tx_busy = 1'b0;
    logic        osc_en, cnt_clr, cnt_en, tx_start, result_valid, busy, err;
    logic [7:0]  tx_data;
    logic [23:0] result;

    ro_meas_sequencer #(
        .CNT_W(16), .ACC_W(24), .SETTLE_CYC(S), .WIN_CYC(W), .LOG2_AVG(L), .TX_TMO(TMO)
    ) dut (
        .clk1(clk1), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .count_in(count_in), .tx_busy(tx_busy), .osc_en(osc_en), .cnt_clr(cnt_clr),
        .cnt_en(cnt_en), .tx_start(tx_start), .tx_data(tx_data), .result(result),
        .result_valid(result_valid), .busy(busy), .err(err)
    );

    always #5 clk1 = ~clk1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART emulation: busy for busy_len cycles after each tx_start, or stuck high.
    int  busy_len = 1;
    bit  stuck = 1'b0;
    int  busy_cnt = 0;
    bit  txs_prev = 1'b0;
    always @(posedge clk1) begin
        #2;
        if (txs_prev) busy_cnt = busy_len;
        if (stuck) tx_busy = 1'b1;
        else if (busy_cnt > 0) begin
            tx_busy = 1'b1;
            busy_cnt--;
        end else tx_busy = 1'b0;
    end

    // Counter stimulus: a fixed value, or a ramp that steps on every counter clear.
    bit          ramp = 1'b0;
    logic [15:0] cnt_fixed = 16'h0000;
    logic [15:0] ramp_val = 16'h0000;
    always @(posedge clk1) begin
        #2;
        if (ramp) begin
            if (cnt_clr) ramp_val = ramp_val + 16'd1;
            count_in = ramp_val;
        end else count_in = cnt_fixed;
    end

    // Model state and observation statistics.
    int          ph = P_IDLE, base = 0, ptr = 0, wd = 0;
    bit          first = 1'b0, cont = 1'b0, merr = 1'b0, mvalid = 1'b0;
    logic [23:0] macc = '0, mres = '0;
    int          txs_cnt = 0, en_cnt = 0, rv_cnt = 0, rv_cyc = 0;
    logic [7:0]  tx_q[$];

    always @(negedge clk1) begin : model
        bit cs, cc, cx;
        int r, k, n;
        logic e_clr, e_en, e_rv, e_txs;
        logic [7:0] e_txd;
        cs = cmd_valid && (cmd_data == 8'h53);
        cc = cmd_valid && (cmd_data == 8'h43);
        cx = cmd_valid && (cmd_data == 8'h58);
        e_clr = 1'b0; e_en = 1'b0; e_rv = 1'b0; e_txs = 1'b0; e_txd = 8'h00;
        r = 0; k = 0; n = 0;
        if (ph == P_MEAS) begin
            r = cyc - base;
            if (r > S) begin
                k = (r - S - 1) % (W + 4);
                n = (r - S - 1) / (W + 4);
                if (n == N) e_rv = 1'b1;
                else begin
                    e_clr = (k == 0);
                    e_en  = (k >= 1) && (k <= W);
                end
            end
        end
        if ((ph == P_TXI) && !tx_busy && !cx) begin
            e_txs = 1'b1;
            e_txd = mres[ptr*8 +: 8];
        end
        if (mvalid) begin
            chk("osc_en", 32'(osc_en), 32'(ph != P_IDLE));
            chk("busy", 32'(busy), 32'(ph != P_IDLE));
            chk("cnt_clr", 32'(cnt_clr), 32'(e_clr));
            chk("cnt_en", 32'(cnt_en), 32'(e_en));
            chk("result_valid", 32'(result_valid), 32'(e_rv));
            chk("tx_start", 32'(tx_start), 32'(e_txs));
            chk("tx_data", 32'(tx_data), 32'(e_txd));
            chk("result", 32'(result), 32'(mres));
            chk("err", 32'(err), 32'(merr));
            if (tx_start === 1'b1) chk("tx_start_while_busy", 32'(tx_busy), 32'd0);
        end
        if (tx_start === 1'b1) begin txs_cnt++; tx_q.push_back(tx_data); end
        if (cnt_en === 1'b1) en_cnt++;
        if (result_valid === 1'b1) begin rv_cnt++; rv_cyc = cyc; end
        txs_prev = (tx_start === 1'b1);

        if (!rst_n) begin
            ph = P_IDLE; cont = 1'b0; macc = '0; mres = '0; merr = 1'b0; wd = 0; mvalid = 1'b1;
        end else begin
            bit in_tx;
            in_tx = (ph == P_TXI) || (ph == P_TXW);
            if (cs || cc) merr = 1'b0;
            if (cx) begin
                cont = 1'b0; wd = 0;
                if (ph != P_IDLE) begin ph = P_IDLE; macc = '0; end
            end else if (ph == P_IDLE) begin
                wd = 0;
                if (cs || cc) begin ph = P_MEAS; base = cyc; cont = cc; macc = '0; end
            end else begin
                if (cc) cont = 1'b1;
                case (ph)
                    P_MEAS: begin
                        if (e_rv) begin ph = P_TXI; ptr = 0; end
                        else if ((r > S) && (k == W + 3)) begin
                            macc = macc + 24'(count_in);
                            if (n == N - 1) mres = macc;
                        end
                    end
                    P_TXI: if (!tx_busy) begin ph = P_TXW; first = 1'b1; end
                    P_TXW: begin
                        if (first) first = 1'b0;
                        else if (!tx_busy) begin
                            if (ptr < 2) begin ptr++; ph = P_TXI; end
                            else if (cont) begin ph = P_MEAS; base = cyc - S; macc = '0; end
                            else ph = P_IDLE;
                        end
                    end
                    default: ;
                endcase
`ifdef ROTEMP_TXWDOG_EN
                if (in_tx && tx_busy) begin
                    wd++;
                    if (wd == TMO) begin
                        merr = 1'b1; ph = P_IDLE; cont = 1'b0; macc = '0; wd = 0;
                    end
                end else wd = 0;
`else
                if (in_tx) wd = 0;
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_data  = b;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
    endtask

    // what: 0 cnt_en high, 1 busy low, 2 rv_cnt > ref_v, 3 txs_cnt > ref_v
    task automatic wait_for(input int what, input int ref_v, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            case (what)
                0:       ok = (cnt_en === 1'b1);
                1:       ok = (busy === 1'b0);
                2:       ok = (rv_cnt > ref_v);
                default: ok = (txs_cnt > ref_v);
            endcase
            if (ok) break;
            tick();
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_%s: not reached within %0d cycles", name, budget);
        end
    endtask

    initial begin : stim
        int s_cyc, t0, q0, e0;
        tick(); tick(); tick();
        chk("reset_osc_en", 32'(osc_en), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_result", 32'(result), 0);
        chk("reset_tx_start", 32'(tx_start), 0);
        chk("reset_err", 32'(err), 0);
        rst_n = 1'b1;
        tick();

        // Single run, 1-cycle UART busy.
        cnt_fixed = 16'h0100; busy_len = 1;
        tick(); tick();
        t0 = txs_cnt; q0 = tx_q.size(); e0 = en_cnt;
        s_cyc = cyc;
        send(8'h53);
        chk("osc_en_after_S", 32'(osc_en), 1);
        wait_for(2, rv_cnt, 200, "rv_single");
        chk("latency_single", 32'(rv_cyc - s_cyc), 61);
        chk("result_single", 32'(result), 32'h000400);
        wait_for(1, 0, 100, "idle_single");
        chk("gate_cycles_single", 32'(en_cnt - e0), 40);
        chk("tx_count_single", 32'(txs_cnt - t0), 3);
        chk("tx_byte0_single", 32'(tx_q[q0]), 32'h00);
        chk("tx_byte1_single", 32'(tx_q[q0+1]), 32'h04);
        chk("tx_byte2_single", 32'(tx_q[q0+2]), 32'h00);
        chk("osc_off_single", 32'(osc_en), 0);

        // Unknown byte and stop while idle do nothing.
        send(8'h41);
        for (int i = 0; i < 4; i++) begin chk("ignored_cmd_busy", 32'(busy), 0); tick(); end
        send(8'h58);
        chk("x_idle_busy", 32'(busy), 0);

        // Continuous with ramping counts, then stop mid-gate.
        ramp = 1'b1;
        tick(); tick();
        send(8'h43);
        wait_for(2, rv_cnt, 200, "rv_cont1");
        chk("result_cont1", 32'(result), 32'h00000A);
        wait_for(2, rv_cnt, 200, "rv_cont2");
        chk("result_cont2", 32'(result), 32'h00001A);
        chk("osc_on_cont", 32'(osc_en), 1);
        wait_for(0, 0, 100, "gate_cont3");
        tick(); tick(); tick();
        send(8'h58);
        chk("x_gate_busy", 32'(busy), 0);
        chk("x_gate_osc", 32'(osc_en), 0);
        chk("x_gate_cnt_en", 32'(cnt_en), 0);
        chk("x_gate_result", 32'(result), 32'h00001A);
        ramp = 1'b0;

        // Backpressure (20-cycle busy) with an ignored 'S' during a gate window.
        cnt_fixed = 16'h0123; busy_len = 20;
        tick(); tick();
        t0 = txs_cnt; q0 = tx_q.size();
        s_cyc = cyc;
        send(8'h53);
        wait_for(0, 0, 50, "gate_bp");
        tick(); tick();
        send(8'h53);
        wait_for(2, rv_cnt, 200, "rv_bp");
        chk("latency_bp", 32'(rv_cyc - s_cyc), 61);
        chk("result_bp", 32'(result), 32'h00048C);
        wait_for(1, 0, 300, "idle_bp");
        chk("tx_count_bp", 32'(txs_cnt - t0), 3);
        chk("tx_byte0_bp", 32'(tx_q[q0]), 32'h8C);
        chk("tx_byte1_bp", 32'(tx_q[q0+1]), 32'h04);
        chk("tx_byte2_bp", 32'(tx_q[q0+2]), 32'h00);

        // Reset while waiting on the UART.
        t0 = txs_cnt;
        send(8'h53);
        wait_for(2, rv_cnt, 200, "rv_rst");
        wait_for(3, t0, 50, "txs_rst");
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("rst_osc_en", 32'(osc_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'({cnt_clr, cnt_en}), 0);
        chk("rst_tx", 32'({tx_start, tx_data}), 0);
        chk("rst_result", 32'({result_valid, result}), 0);
        rst_n = 1'b1;
        repeat (25) tick();

        // Transmitter stuck busy.
        stuck = 1'b1; busy_len = 1;
        cnt_fixed = 16'h0001;
        tick(); tick();
        t0 = txs_cnt;
        send(8'h53);
        wait_for(2, rv_cnt, 200, "rv_stuck");
`ifdef ROTEMP_TXWDOG_EN
        repeat (7) tick();
        chk("wd_busy_before_trip", 32'(busy), 1);
        tick();
        chk("wd_busy_after_trip", 32'(busy), 0);
        chk("wd_err_set", 32'(err), 1);
        chk("wd_result_held", 32'(result), 32'h000004);
        stuck = 1'b0;
        tick(); tick();
        send(8'h53);
        chk("wd_err_cleared", 32'(err), 0);
        chk("wd_restart_busy", 32'(busy), 1);
        send(8'h58);
`else
        repeat (20) tick();
        chk("nowd_still_busy", 32'(busy), 1);
        chk("nowd_err", 32'(err), 0);
        chk("nowd_no_tx", 32'(txs_cnt - t0), 0);
        send(8'h58);
        chk("nowd_x_idle", 32'(busy), 0);
        stuck = 1'b0;
`endif
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
